// File: rtl/fwd_sel_if.sv
// ID-to-EX hazard/forwarding bundle: ID fields, freeze/squash controls, stall and EX-slot state.
// The slave modport is the controller; master is the pipeline side driving ID.
interface fwd_sel_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  ext_stall;
  logic                  flush;
  logic                  stall_o;
  logic [1:0]            sel_a;
  logic [1:0]            sel_b;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read,
    output ext_stall, flush,
    input  stall_o, sel_a, sel_b, ex_valid, ex_rd, ex_reg_write
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read,
    input  ext_stall, flush,
    output stall_o, sel_a, sel_b, ex_valid, ex_rd, ex_reg_write
  );
endinterface

// File: rtl/fwd_sel_pipe.sv
// EX operand-mux select/forwarding controller with load-use stall FSM; sel/EX registered (1 cycle), stall_o combinational.
// ext_stall freezes all state, flush squashes ID and aborts a stall; FWD_STATS_EN adds fwd/stall counters.
module fwd_sel_pipe #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int CNT_W             = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  fwd_sel_if.slave         io
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] fwd_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic {RUN, STALL} state_e;

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_FWD  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] CNT_INIT = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic [1:0]            sel_a_q, sel_a_d;
  logic [1:0]            sel_b_q, sel_b_d;

  logic                  ld_use;
  logic                  stall;
  logic                  take_id;
  logic                  make_bubble;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;

  assign ld_use = io.id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                  ((ex_rd_q == io.id_rs) || (io.id_uses_rt && (ex_rd_q == io.id_rt)));
  assign stall  = !io.flush && ((state_q == STALL) || ((state_q == RUN) && ld_use));

  // The instruction currently in EX moves to MEM at this edge, so it is the forwarding source.
  always_comb begin
    fwd_a = SEL_REG;
    fwd_b = SEL_REG;
    if (io.id_rs == '0) begin
      fwd_a = SEL_ZERO;
    end else if (ex_valid_q && ex_reg_write_q && (ex_rd_q == io.id_rs)) begin
      fwd_a = SEL_FWD;
    end
    if (!io.id_uses_rt) begin
      fwd_b = SEL_REG;
    end else if (io.id_rt == '0) begin
      fwd_b = SEL_ZERO;
    end else if (ex_valid_q && ex_reg_write_q && (ex_rd_q == io.id_rt)) begin
      fwd_b = SEL_FWD;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    sel_a_d        = sel_a_q;
    sel_b_d        = sel_b_q;
    take_id        = 1'b0;
    make_bubble    = 1'b0;

    if (io.flush) begin
      make_bubble = 1'b1;
      state_d     = RUN;
      cnt_d       = 2'd0;
    end else if (!io.ext_stall) begin
      if (stall) begin
        make_bubble = 1'b1;
        if (state_q == RUN) begin
          // A single-cycle stall needs no FSM state: the bubble itself clears ld_use.
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end else if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end else if (io.id_valid) begin
        take_id = 1'b1;
      end else begin
        make_bubble = 1'b1;
      end
    end

    if (make_bubble) begin
      ex_valid_d     = 1'b0;
      ex_rd_d        = '0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      sel_a_d        = SEL_ZERO;
      sel_b_d        = SEL_ZERO;
    end else if (take_id) begin
      ex_valid_d     = 1'b1;
      ex_rd_d        = io.id_rd;
      ex_reg_write_d = io.id_reg_write;
      ex_mem_read_d  = io.id_mem_read;
      sel_a_d        = fwd_a;
      sel_b_d        = fwd_b;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= RUN;
      cnt_q          <= 2'd0;
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      sel_a_q        <= SEL_ZERO;
      sel_b_q        <= SEL_ZERO;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      sel_a_q        <= sel_a_d;
      sel_b_q        <= sel_b_d;
    end
  end

  assign io.stall_o      = stall;
  assign io.sel_a        = sel_a_q;
  assign io.sel_b        = sel_b_q;
  assign io.ex_valid     = ex_valid_q;
  assign io.ex_rd        = ex_rd_q;
  assign io.ex_reg_write = ex_reg_write_q;

`ifdef FWD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // take_id already excludes ext_stall and flush cycles, so both counters hold on a freeze.
  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (take_id && ((fwd_a == SEL_FWD) || (fwd_b == SEL_FWD)) && !(&fwd_cnt_q)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_ONE;
    end
    if (stall && !io.ext_stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_count   = fwd_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Directed-vector bench for fwd_sel_pipe: driver queues hand-computed stall_o and EX-slot
// expectations; monitors pop them at negedge (stall_o) and just after posedge (EX registers).
module tb_fwd_sel_pipe;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] sa;
    logic [1:0] sb;
  } ex_t;

  logic Clk = 1'b0;
  logic Rst_n;

  fwd_sel_if #(.REG_ADDR_W(5)) bus ();

`ifdef FWD_STATS_EN
  logic [15:0] fwd_count;
  logic [15:0] stall_count;
`endif

  fwd_sel_pipe #(
    .REG_ADDR_W       (5),
    .LOAD_STALL_CYCLES(2),
    .CNT_W            (16)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .io   (bus)
`ifdef FWD_STATS_EN
    ,
    .fwd_count  (fwd_count),
    .stall_count(stall_count)
`endif
  );

  always #5 Clk = ~Clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   vec_no  = 0;
  int   exp_fwd = 0;
  int   exp_stl = 0;
  logic stq[$];
  ex_t  exq[$];
  int   stn[$];
  int   exn[$];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic ex_t mk(input logic v, input logic [4:0] rd, input logic rw,
                             input logic [1:0] sa, input logic [1:0] sb);
    ex_t e;
    e.v  = v;
    e.rd = rd;
    e.rw = rw;
    e.sa = sa;
    e.sb = sb;
    return e;
  endfunction

  function automatic ex_t bub();
    return mk(1'b0, 5'd0, 1'b0, 2'b10, 2'b10);
  endfunction

  // One clock of stimulus: drive ID/control, queue the expected stall_o for this cycle and
  // the expected EX slot after the coming edge, then advance past that edge.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                     input logic [4:0] rd, input logic rw, input logic mr,
                     input logic es, input logic fl, input logic e_st, input ex_t e);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rt   = ut;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.ext_stall    = es;
    bus.flush        = fl;
    vec_no++;
    stq.push_back(e_st);
    stn.push_back(vec_no);
    exq.push_back(e);
    exn.push_back(vec_no);
    if (e_st && !es) exp_stl++;
    if (!es && !fl && e.v && (e.sa == 2'b01 || e.sb == 2'b01)) exp_fwd++;
    @(posedge Clk);
    #2;
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, bub());
  endtask

  task automatic lw8();
    cyc(1, 9, 8, 0, 8, 1, 1, 0, 0, 1'b0, mk(1, 8, 1, 2'b00, 2'b00));
  endtask

  task automatic chk_reset_outputs(input int tag);
    chk("rst_stall_o", tag, 16'(bus.stall_o), 16'd0);
    chk("rst_sel_a", tag, 16'(bus.sel_a), 16'h2);
    chk("rst_sel_b", tag, 16'(bus.sel_b), 16'h2);
    chk("rst_ex_valid", tag, 16'(bus.ex_valid), 16'd0);
    chk("rst_ex_rd", tag, 16'(bus.ex_rd), 16'd0);
    chk("rst_ex_reg_write", tag, 16'(bus.ex_reg_write), 16'd0);
  endtask

  initial begin : stall_monitor
    forever begin
      @(negedge Clk);
      if (stq.size() > 0) begin
        chk("stall_o", stn.pop_front(), 16'(bus.stall_o), 16'(stq.pop_front()));
      end
    end
  end

  initial begin : ex_monitor
    ex_t obs;
    forever begin
      @(posedge Clk);
      #1;
      if (exq.size() > 0) begin
        obs = mk(bus.ex_valid, bus.ex_rd, bus.ex_reg_write, bus.sel_a, bus.sel_b);
        chk("ex_slot{v,rd,rw,sa,sb}", exn.pop_front(), 16'(obs), 16'(exq.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : driver
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.id_rd = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.ext_stall = 0; bus.flush = 0;
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #1 chk_reset_outputs(0);
`ifdef FWD_STATS_EN
    chk("rst_fwd_count", 0, fwd_count, 16'd0);
    chk("rst_stall_count", 0, stall_count, 16'd0);
`endif
    repeat (2) @(posedge Clk);
    #2 Rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5 -> forward rs
    cyc(1, 1, 2, 1, 3, 1, 0, 0, 0, 1'b0, mk(1, 3, 1, 2'b00, 2'b00));
    cyc(1, 3, 5, 1, 4, 1, 0, 0, 0, 1'b0, mk(1, 4, 1, 2'b01, 2'b00));
    nop();

    // lw $8 ; add $10,$8,$8 -> two stall cycles, two bubbles, then no forwarding
    lw8();
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b1, bub());
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b1, bub());
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b0, mk(1, 10, 1, 2'b00, 2'b00));
    nop();

    // flush in the first stall cycle
    lw8();
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 1, 1'b0, bub());
    nop();

    // flush while in STALL
    lw8();
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b1, bub());
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 1, 1'b0, bub());
    nop();

    // $zero handling and rt forwarding / uses_rt masking
    cyc(1, 1, 2, 1, 0, 1, 0, 0, 0, 1'b0, mk(1, 0, 1, 2'b00, 2'b00));
    cyc(1, 0, 7, 1, 5, 1, 0, 0, 0, 1'b0, mk(1, 5, 1, 2'b10, 2'b00));
    cyc(1, 2, 5, 1, 6, 1, 0, 0, 0, 1'b0, mk(1, 6, 1, 2'b00, 2'b01));
    cyc(1, 1, 6, 0, 7, 1, 0, 0, 0, 1'b0, mk(1, 7, 1, 2'b00, 2'b00));
    nop();

    // load into $0 never causes a load-use stall
    cyc(1, 9, 0, 0, 0, 1, 1, 0, 0, 1'b0, mk(1, 0, 1, 2'b00, 2'b00));
    cyc(1, 0, 0, 1, 5, 1, 0, 0, 0, 1'b0, mk(1, 5, 1, 2'b10, 2'b10));
    nop();

    // ext_stall for 3 cycles during STALL, then resume
    lw8();
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b1, bub());
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8, 8, 1, 10, 1, 0, 1, 0, 1'b1, bub());
    end
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b1, bub());
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b0, mk(1, 10, 1, 2'b00, 2'b00));
    // flush beats ext_stall
    cyc(1, 1, 2, 1, 3, 1, 0, 1, 1, 1'b0, bub());
    // ext_stall holds a real EX instruction, then forwarding on both operands
    cyc(1, 3, 4, 1, 5, 1, 0, 0, 0, 1'b0, mk(1, 5, 1, 2'b00, 2'b00));
    cyc(1, 5, 5, 1, 6, 1, 0, 1, 0, 1'b0, mk(1, 5, 1, 2'b00, 2'b00));
    cyc(1, 5, 5, 1, 6, 1, 0, 0, 0, 1'b0, mk(1, 6, 1, 2'b01, 2'b01));
    nop();

`ifdef FWD_STATS_EN
    chk("fwd_count", vec_no, fwd_count, 16'(exp_fwd));
    chk("stall_count", vec_no, stall_count, 16'(exp_stl));
`endif

    // reset asserted mid-cycle while the FSM is in STALL
    lw8();
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b1, bub());
    #3 Rst_n = 1'b0;
    #1 chk_reset_outputs(vec_no);
`ifdef FWD_STATS_EN
    chk("rst_stall_count_mid", vec_no, stall_count, 16'd0);
`endif
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    cyc(1, 8, 8, 1, 10, 1, 0, 0, 0, 1'b0, mk(1, 10, 1, 2'b00, 2'b00));
    nop();

    repeat (3) @(posedge Clk);
    #2;
    if (stq.size() != 0 || exq.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d stall and %0d ex expectations left, expected 0",
               stq.size(), exq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
